// File: rtl/calc_sequencer.sv
// Micro-sequencer: fetches 12-bit instructions from a small program memory and
// drives an external ALU, holding four general registers and a carry flag.
module calc_sequencer #(
   parameter int unsigned PROG_DEPTH = 16,
   parameter int unsigned DATA_W     = 8,
   localparam int unsigned PC_W      = $clog2(PROG_DEPTH),
   localparam int unsigned IR_W      = 12
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              prog_we,
   input  logic [PC_W-1:0]   prog_addr,
   input  logic [IR_W-1:0]   prog_data,
   input  logic              start,
   input  logic              stop,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [3:0]        alu_sel,
   input  logic [DATA_W-1:0] alu_out,
   input  logic              alu_cout,
   output logic              busy,
   output logic              done,
   output logic [PC_W-1:0]   pc,
   output logic [DATA_W-1:0] result,
   output logic              carry
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_EXEC  = 3'd2,
      S_WRITE = 3'd3,
      S_HALT  = 3'd4
   } state_t;

   localparam logic [1:0] C_ALU  = 2'b00;
   localparam logic [1:0] C_LDI  = 2'b01;
   localparam logic [1:0] C_JMP  = 2'b10;
   localparam logic [1:0] C_HALT = 2'b11;

   state_t            state;
   state_t            state_nxt;
   logic              busy_nxt;
   logic              done_nxt;
   logic [IR_W-1:0]   ir;
   logic [DATA_W-1:0] regs [4];
   logic [IR_W-1:0]   mem  [PROG_DEPTH];
   logic              parked;
   logic              launch;

   assign parked = (state == S_IDLE) || (state == S_HALT);
   assign launch = parked && start && !prog_we;
   assign result = regs[0];

   // Next-state and registered-output decode
   always_comb begin
      state_nxt = state;
      done_nxt  = 1'b0;
      case (state)
         S_IDLE, S_HALT: if (launch) state_nxt = S_FETCH;
         S_FETCH:        state_nxt = stop ? S_IDLE : S_EXEC;
         S_EXEC: begin
            if (stop) begin
               state_nxt = S_IDLE;
            end else begin
               case (ir[11:10])
                  C_ALU:   state_nxt = S_WRITE;
                  C_HALT: begin
                     state_nxt = S_HALT;
                     done_nxt  = 1'b1;
                  end
                  default: state_nxt = S_FETCH;
               endcase
            end
         end
         S_WRITE:        state_nxt = stop ? S_IDLE : S_FETCH;
         default:        state_nxt = S_IDLE;
      endcase
      busy_nxt = (state_nxt == S_FETCH) || (state_nxt == S_EXEC) || (state_nxt == S_WRITE);
   end

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         busy  <= busy_nxt;
         done  <= done_nxt;
      end
   end

   // Datapath: every update is suppressed on a stop so an abort leaves no trace
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc      <= '0;
         ir      <= '0;
         carry   <= 1'b0;
         alu_a   <= '0;
         alu_b   <= '0;
         alu_sel <= '0;
         for (int i = 0; i < 4; i++) regs[i] <= '0;
      end else begin
         case (state)
            S_IDLE, S_HALT: if (launch) pc <= '0;
            S_FETCH:        if (!stop) ir <= mem[pc];
            S_EXEC: begin
               if (!stop) begin
                  case (ir[11:10])
                     C_ALU: begin
                        alu_a   <= regs[ir[3:2]];
                        alu_b   <= regs[ir[1:0]];
                        alu_sel <= ir[9:6];
                     end
                     C_LDI: begin
                        regs[ir[9:8]] <= DATA_W'(ir[7:0]);
                        pc            <= pc + PC_W'(1);
                     end
                     C_JMP: pc <= (!ir[9] || carry) ? PC_W'(ir[3:0]) : pc + PC_W'(1);
                     default: ;
                  endcase
               end
            end
            S_WRITE: begin
               if (!stop) begin
                  regs[ir[5:4]] <= alu_out;
                  if (alu_sel == 4'b0000) carry <= alu_cout;
                  pc <= pc + PC_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // Program memory has no reset so a loaded program survives reset_n
   always_ff @(posedge clk) begin
      if (prog_we && parked) mem[prog_addr] <= prog_data;
   end

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: instruction-level reference model expanded into
// per-cycle expected outputs, directed programs plus randomized programs/controls.
module tb_calc_sequencer;

   logic        clk = 1'b0;
   logic        reset_n, prog_we, start, stop;
   logic [3:0]  prog_addr;
   logic [11:0] prog_data;
   logic [7:0]  alu_a, alu_b, alu_out, result;
   logic [3:0]  alu_sel, pc;
   logic        alu_cout, busy, done, carry;

   calc_sequencer dut (
      .clk(clk), .reset_n(reset_n), .prog_we(prog_we), .prog_addr(prog_addr),
      .prog_data(prog_data), .start(start), .stop(stop), .alu_a(alu_a),
      .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out), .alu_cout(alu_cout),
      .busy(busy), .done(done), .pc(pc), .result(result), .carry(carry)
   );

   always #5 clk = ~clk;

   // External ALU; only sel 0 (add) reaches the carry flag
   function automatic logic [8:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                         input logic [3:0] s);
      case (s)
         4'd0:    return {1'b0, a} + {1'b0, b};
         4'd1:    return {1'b0, a} - {1'b0, b};
         4'd2:    return {1'b0, a & b};
         4'd3:    return {1'b1, a | b};
         4'd4:    return {1'b0, a ^ b};
         default: return {1'b1, ~a};
      endcase
   endfunction

   assign {alu_cout, alu_out} = alu_fn(alu_a, alu_b, alu_sel);

   function automatic logic [11:0] ldi(input logic [1:0] d, input logic [7:0] imm);
      return {2'b01, d, imm};
   endfunction
   function automatic logic [11:0] alu_i(input logic [3:0] s, input logic [1:0] d,
                                         input logic [1:0] a, input logic [1:0] b);
      return {2'b00, s, d, a, b};
   endfunction
   function automatic logic [11:0] jmp(input logic c, input logic [3:0] t);
      return {2'b10, c, 5'b0, t};
   endfunction
   localparam logic [11:0] HALT = 12'hC00;

   typedef struct packed {
      logic [3:0]      pc;
      logic [3:0][7:0] r;
      logic            c;
      logic [7:0]      a;
      logic [7:0]      b;
      logic [3:0]      sel;
      logic            busy;
      logic            done;
   } snap_t;

   snap_t       vis;
   snap_t       q[$];
   bit          running;
   logic [11:0] mem  [16];
   logic [11:0] prog [16];
   int          n_cmp = 0;
   int          n_bad = 0;
   bit          chk_en = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %h want %h", name, $time, act, exp);
      end
   endtask

   // Run one whole instruction atomically, then spread its visible effects over its latency
   task automatic exec_instr();
      snap_t       s;
      logic [11:0] w;
      logic [8:0]  ar;
      s = vis;
      s.done = 1'b0;
      w = mem[vis.pc];
      q.push_back(s);
      case (w[11:10])
         2'b00: begin
            s.a = s.r[w[3:2]];
            s.b = s.r[w[1:0]];
            s.sel = w[9:6];
            q.push_back(s);
            ar = alu_fn(s.a, s.b, s.sel);
            s.r[w[5:4]] = ar[7:0];
            if (s.sel == 4'd0) s.c = ar[8];
            s.pc = s.pc + 4'd1;
         end
         2'b01: begin
            s.r[w[9:8]] = w[7:0];
            s.pc = s.pc + 4'd1;
         end
         2'b10: s.pc = (!w[9] || s.c) ? w[3:0] : s.pc + 4'd1;
         default: begin
            s.busy = 1'b0;
            s.done = 1'b1;
         end
      endcase
      q.push_back(s);
   endtask

   // Advance the model across one clock edge using the inputs presented at that edge
   task automatic model_step();
      if (!reset_n) begin
         vis = '0;
         q.delete();
         running = 1'b0;
         return;
      end
      vis.done = 1'b0;
      if (!running) begin
         if (prog_we) mem[prog_addr] = prog_data;
         else if (start) begin
            vis.pc = 4'd0;
            vis.busy = 1'b1;
            running = 1'b1;
         end
         return;
      end
      if (stop) begin
         q.delete();
         vis.busy = 1'b0;
         running = 1'b0;
         return;
      end
      if (q.size() == 0) exec_instr();
      vis = q.pop_front();
      if (!vis.busy) running = 1'b0;
   endtask

   always @(negedge clk) begin
      if (chk_en)
         check("cycle", 64'({pc, result, carry, alu_a, alu_b, alu_sel, busy, done}),
               64'({vis.pc, vis.r[0], vis.c, vis.a, vis.b, vis.sel, vis.busy, vis.done}));
   end

   task automatic step();
      @(posedge clk);
      #1;
      model_step();
   endtask

   task automatic load_prog();
      for (int i = 0; i < 16; i++) begin
         prog_we = 1'b1;
         prog_addr = 4'(i);
         prog_data = prog[i];
         step();
      end
      prog_we = 1'b0;
   endtask

   task automatic clear_prog();
      for (int i = 0; i < 16; i++) prog[i] = HALT;
   endtask

   task automatic run_prog(input bit we_busy, output int n);
      start = 1'b1;
      step();
      start = 1'b0;
      n = 0;
      while (done !== 1'b1 && n < 300) begin
         if (we_busy && n < 3) begin
            prog_we = 1'b1;
            prog_addr = 4'd6;
            prog_data = ldi(2'd0, 8'h11);
         end else begin
            prog_we = 1'b0;
         end
         step();
         n++;
      end
      prog_we = 1'b0;
      if (n >= 300) check("run_timeout", 64'(done), 64'(1));
   endtask

   task automatic pulse_reset();
      #2;
      reset_n = 1'b0;
      model_step();
      step();
      reset_n = 1'b1;
   endtask

   initial begin
      int n;
      reset_n = 1'b1; prog_we = 1'b0; start = 1'b0; stop = 1'b0;
      prog_addr = '0; prog_data = '0;
      vis = '0; running = 1'b0;
      for (int i = 0; i < 16; i++) mem[i] = '0;
      #1 reset_n = 1'b0;
      model_step();
      #1;
      check("reset_outs", 64'({pc, result, carry, alu_a, alu_b, alu_sel, busy, done}), 64'(0));
      chk_en = 1'b1;
      step(); step();
      reset_n = 1'b1;

      // add program: 5 + 3
      clear_prog();
      prog[0] = ldi(2'd1, 8'h05);
      prog[1] = ldi(2'd2, 8'h03);
      prog[2] = alu_i(4'd0, 2'd0, 2'd1, 2'd2);
      load_prog();
      run_prog(1'b0, n);
      check("add_done_latency", 64'(n), 64'(9));
      check("add_result", 64'(result), 64'(8'h08));
      check("add_carry", 64'(carry), 64'(0));
      check("add_pc", 64'(pc), 64'(3));
      step();
      check("done_one_cycle", 64'(done), 64'(0));

      // overflow sets carry, conditional jump taken
      clear_prog();
      prog[0] = ldi(2'd1, 8'hFF);
      prog[1] = ldi(2'd2, 8'h01);
      prog[2] = alu_i(4'd0, 2'd0, 2'd1, 2'd2);
      prog[3] = jmp(1'b1, 4'd6);
      prog[4] = ldi(2'd3, 8'hAA);
      prog[5] = ldi(2'd3, 8'hBB);
      load_prog();
      run_prog(1'b0, n);
      check("jmp_result", 64'(result), 64'(8'h00));
      check("jmp_carry", 64'(carry), 64'(1));
      check("jmp_pc", 64'(pc), 64'(6));

      // no overflow: jump falls through
      prog[1] = ldi(2'd2, 8'h00);
      prog[4] = HALT;
      load_prog();
      run_prog(1'b0, n);
      check("fall_result", 64'(result), 64'(8'hFF));
      check("fall_carry", 64'(carry), 64'(0));
      check("fall_pc", 64'(pc), 64'(4));

      // write beats start; writes while busy are dropped
      prog_we = 1'b1; prog_addr = 4'd4; prog_data = ldi(2'd0, 8'h77); start = 1'b1;
      step();
      prog_we = 1'b0; start = 1'b0;
      check("we_start_idle", 64'(busy), 64'(0));
      run_prog(1'b1, n);
      check("we_result", 64'(result), 64'(8'h77));
      check("we_pc", 64'(pc), 64'(6));

      // endless LDI program: pc wraps, stop aborts
      for (int i = 0; i < 16; i++) prog[i] = ldi(2'(i), 8'(i));
      load_prog();
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (30) step();
      check("wrap_pc15", 64'(pc), 64'(15));
      repeat (2) step();
      check("wrap_pc0", 64'(pc), 64'(0));
      check("wrap_busy", 64'(busy), 64'(1));
      stop = 1'b1;
      step();
      stop = 1'b0;
      check("stop_busy", 64'(busy), 64'(0));
      check("stop_done", 64'(done), 64'(0));
      check("stop_pc", 64'(pc), 64'(0));
      step();
      check("stop_no_done", 64'(done), 64'(0));

      // reset during the add's WRITE cycle
      clear_prog();
      prog[0] = ldi(2'd1, 8'h05);
      prog[1] = ldi(2'd2, 8'h03);
      prog[2] = alu_i(4'd0, 2'd0, 2'd1, 2'd2);
      load_prog();
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (6) step();
      check("pre_reset_alu_a", 64'(alu_a), 64'(8'h05));
      #2 reset_n = 1'b0;
      model_step();
      #1;
      check("midreset_outs", 64'({pc, result, carry, alu_a, alu_b, alu_sel, busy, done}), 64'(0));
      step(); step();
      reset_n = 1'b1;
      step();
      check("post_reset_idle", 64'(busy), 64'(0));
      run_prog(1'b0, n);
      check("rerun_latency", 64'(n), 64'(9));
      check("rerun_result", 64'(result), 64'(8'h08));
      check("rerun_pc", 64'(pc), 64'(3));

      // randomized programs and control traffic
      for (int it = 0; it < 4; it++) begin
         for (int i = 0; i < 16; i++) begin
            case ($urandom_range(0, 9))
               0, 1, 2, 3: prog[i] = alu_i(($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'd0,
                                           2'($urandom), 2'($urandom), 2'($urandom));
               4, 5, 6:    prog[i] = ldi(2'($urandom), 8'($urandom));
               7, 8:       prog[i] = jmp(1'($urandom), 4'($urandom));
               default:    prog[i] = HALT;
            endcase
         end
         load_prog();
         for (int c = 0; c < 600; c++) begin
            start = ($urandom_range(0, 7) == 0);
            stop = ($urandom_range(0, 40) == 0);
            prog_we = ($urandom_range(0, 15) == 0);
            prog_addr = 4'($urandom);
            prog_data = 12'($urandom);
            step();
            if ($urandom_range(0, 249) == 0) pulse_reset();
         end
         start = 1'b0; stop = 1'b0; prog_we = 1'b0;
         stop = 1'b1;
         step();
         stop = 1'b0;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/calc_sequencer.md
CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 Parameter: PROG_DEPTH, default 16, number of program words; fixed at 16, so pc is 4 bits.
REQ-002 Parameter: DATA_W, default 8, register and ALU operand width.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, with ports listed below.
REQ-004 Ports SHALL be:
  - clk  in  1  rising-edge clock.
  - reset_n  in  1  asynchronous active-low reset.
  - prog_we  in  1  program-memory write strobe.
  - prog_addr  in  4  program write address.
  - prog_data  in  12  program word.
  - start  in  1  run request, pulse.
  - stop  in  1  abort request.
  - alu_a  out  8  ALU operand A.
  - alu_b  out  8  ALU operand B.
  - alu_sel  out  4  ALU function select.
  - alu_out  in  8  ALU result.
  - alu_cout  in  1  ALU carry.
  - busy  out  1  program running.
  - done  out  1  one-cycle pulse on HALT.
  - pc  out  4  current program counter.
  - result  out  8  register R0.
  - carry  out  1  carry flag.

Function
REQ-005 The block SHALL contain 16x12 program memory, four 8-bit registers R0-R3, a 12-bit IR, a 4-bit pc and a carry flag.
REQ-006 Instruction classes SHALL be decoded from ir[11:10] as follows:
  - 00 ALU: sel=[9:6], dst=[5:4], srcA=[3:2], srcB=[1:0].
  - 01 LDI: dst=[9:8], imm=[7:0].
  - 10 JMP: cond=[9], target=[3:0].
  - 11 HALT.
REQ-007 The FSM SHALL have the states IDLE, FETCH, EXEC, WRITE and HALT.
REQ-008 In IDLE or HALT, start=1 with prog_we=0 SHALL set pc=0 and go to FETCH; start in any other state SHALL be ignored.
REQ-009 In FETCH, IR SHALL load mem[pc] and the FSM SHALL go to EXEC.
REQ-010 In EXEC for ALU class, alu_a<=R[srcA], alu_b<=R[srcB] and alu_sel<=sel SHALL register, and the FSM SHALL go to WRITE.
REQ-011 In WRITE, R[dst]<=alu_out SHALL occur; if sel==4'b0000, carry<=alu_cout, otherwise carry is unchanged; pc SHALL increment, and the FSM SHALL go to FETCH.
REQ-012 In EXEC for LDI, R[dst]<=imm SHALL occur, pc SHALL increment, and the FSM SHALL go to FETCH.
REQ-013 In EXEC for JMP, pc<=target SHALL occur if cond==0 or carry==1, otherwise pc SHALL increment; the FSM SHALL go to FETCH.
REQ-014 In EXEC for HALT, the FSM SHALL go to HALT with pc unchanged, and done SHALL be 1 for exactly that transition cycle.
REQ-015 Latency SHALL be 3 cycles for ALU, 2 for LDI, 2 for JMP, and 2 for HALT, counted from entering FETCH.
REQ-016 pc increment SHALL wrap from 15 to 0 with no flag.
REQ-017 busy SHALL be 1 in FETCH, EXEC and WRITE, and 0 in IDLE and HALT.
REQ-018 prog_we SHALL write mem[prog_addr]<=prog_data only in IDLE or HALT and be ignored otherwise; if start coincides with prog_we, the write wins and start is dropped.
REQ-019 stop=1 in any busy state SHALL force IDLE on the next edge, with no register write, no pc change, no done pulse, and alu_* holding their values; stop has priority over start.
REQ-020 src==dst SHALL be legal; the write uses the operand values sampled in EXEC.
REQ-021 result SHALL continuously reflect R0, and carry SHALL reflect the flag register.

Reset
REQ-022 While reset_n=0, the block SHALL asynchronously force state=IDLE and clear pc, IR, R0-R3, carry, alu_a, alu_b, alu_sel, done and busy to 0.
REQ-023 Program memory SHALL NOT be reset; contents SHALL be retained across reset.
REQ-024 Reset asserted mid-instruction SHALL abandon it with no write; after release the block SHALL wait in IDLE for start.

Verification
REQ-025 LDI R1,0x05; LDI R2,0x03; ALU add R0=R1+R2; HALT; start -> result=0x08, carry=0, done pulses once 9 cycles after start is sampled, pc=3.
REQ-026 LDI R1,0xFF; LDI R2,0x01; add R0; JMP cond=1 to 6; mem[6]=HALT -> result=0x00, carry=1, final pc=6.
REQ-027 Same program with R2=0x00 -> carry=0; the JMP falls through to pc=4.
REQ-028 A program filling all 16 words with LDI and no HALT -> pc wraps 15 to 0 and busy stays 1; stop -> IDLE next cycle, busy=0, no done.
REQ-029 prog_we and start on the same cycle in IDLE -> memory written, state stays IDLE; prog_we while busy -> memory unchanged.
REQ-030 reset_n driven low during WRITE of an add -> all outputs 0 immediately; after release the same start reproduces the correct result, and program memory is intact.
